// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg
//   Shared memory-request types and the port-id width rule.
//   Revision: 1.0
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int PHYS_ADDR_W = 21;
  localparam int MEM_DATA_W  = 64;

  typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

  typedef struct packed {
    logic                  write;
    phys_memory_address_t  addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // A single-client arbiter still carries a 1-bit port id.
  function automatic int port_id_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_tag_fifo.sv
`default_nettype none
// ============================================================================
// port_tag_fifo
//   Synchronous FIFO with async reset; explicit count for full/empty.
//   Revision: 1.0
// ============================================================================
module port_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
//   Round-robin N-port memory request arbiter with in-order response routing.
//   Revision: 1.0
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 21,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              up_req_valid,
  output logic [NUM_PORTS-1:0]              up_req_ready,
  input  logic [NUM_PORTS-1:0]              up_req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]       up_req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]       up_req_wdata,
  output logic [NUM_PORTS-1:0]              up_rsp_valid,
  output logic [DATA_W-1:0]                 up_rsp_rdata,
  output logic                              dn_req_valid,
  input  logic                              dn_req_ready,
  output logic                              dn_req_write,
  output logic [ADDR_W-1:0]                 dn_req_addr,
  output logic [DATA_W-1:0]                 dn_req_wdata,
  output logic [port_id_w(NUM_PORTS)-1:0]   dn_req_port,
  input  logic                              dn_rsp_valid,
  input  logic [DATA_W-1:0]                 dn_rsp_rdata,
  output logic                              err_orphan_rsp
);

  localparam int PORT_W = port_id_w(NUM_PORTS);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic              found;
    logic [PORT_W-1:0] idx;
  } pick_t;

  // Lowest rotational distance from the pointer wins.
  function automatic pick_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                    input logic [PORT_W-1:0]    ptr);
    pick_t res;
    int    best_off;
    int    off;
    res      = '0;
    best_off = NUM_PORTS;
    for (int p = 0; p < NUM_PORTS; p++) begin
      off = (p + NUM_PORTS - int'(ptr)) % NUM_PORTS;
      if (req[p] && (off < best_off)) begin
        best_off  = off;
        res.found = 1'b1;
        res.idx   = PORT_W'(p);
      end
    end
    return res;
  endfunction

  logic                 r_stage_valid;
  logic                 r_stage_write;
  logic [ADDR_W-1:0]    r_stage_addr;
  logic [DATA_W-1:0]    r_stage_wdata;
  logic [PORT_W-1:0]    r_stage_port;
  logic [PORT_W-1:0]    r_rr_ptr;
  logic                 r_err;

  pick_t                w_pick;
  logic                 w_can_accept;
  logic                 w_accept;
  logic [CNT_W-1:0]     w_inflight;
  logic                 w_sel_write;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_push;
  logic                 w_pop;
  logic [PORT_W-1:0]    w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [CNT_W-1:0]     w_fifo_count;

  // A response popping this cycle deliberately does not free a slot.
  assign w_inflight   = CNT_W'(r_stage_valid) + w_fifo_count;
  assign w_can_accept = (~r_stage_valid | dn_req_ready) &
                        (w_inflight < CNT_W'(MAX_OUTSTANDING));
  assign w_pick       = rr_pick(up_req_valid, r_rr_ptr);
  assign w_accept     = ~reset & w_can_accept & w_pick.found;
  assign up_req_ready = w_accept ? (NUM_PORTS'(1) << w_pick.idx) : '0;

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_pick.idx == PORT_W'(p)) begin
        w_sel_write = up_req_write[p];
        w_sel_addr  = up_req_addr[p*ADDR_W +: ADDR_W];
        w_sel_wdata = up_req_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage_valid <= 1'b0;
      r_stage_write <= 1'b0;
      r_stage_addr  <= '0;
      r_stage_wdata <= '0;
      r_stage_port  <= '0;
      r_rr_ptr      <= '0;
    end else if (w_accept) begin
      r_stage_valid <= 1'b1;
      r_stage_write <= w_sel_write;
      r_stage_addr  <= w_sel_addr;
      r_stage_wdata <= w_sel_wdata;
      r_stage_port  <= w_pick.idx;
      r_rr_ptr      <= PORT_W'((int'(w_pick.idx) + 1) % NUM_PORTS);
    end else if (dn_req_ready) begin
      r_stage_valid <= 1'b0;
    end
  end

  assign dn_req_valid = r_stage_valid;
  assign dn_req_write = r_stage_write;
  assign dn_req_addr  = r_stage_addr;
  assign dn_req_wdata = r_stage_wdata;
  assign dn_req_port  = r_stage_port;

  assign w_pop  = dn_rsp_valid & ~w_fifo_empty;
  assign w_push = r_stage_valid & dn_req_ready & (~w_fifo_full | w_pop);

  port_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (PORT_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (r_stage_port),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign up_rsp_valid = w_pop ? (NUM_PORTS'(1) << w_head) : '0;
  assign up_rsp_rdata = w_pop ? dn_rsp_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (dn_rsp_valid && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err_orphan_rsp = r_err;

endmodule
`default_nettype wire
